video_timing: RTL and testbench

Raster timing generator that sits directly upstream of the character-map renderer. Produces a pixel clock enable, 9-bit horizontal/vertical beam counters (hcnt/vcnt, consumed unchanged by the charmap stage), sync, blanking and data-enable. Also produces a one-clock vertical-blank interrupt strobe for the CPU and a frame counter. Default timing is a 320x240 visible raster at 400x262 total.

---
 rtl/video_timing_pkg.sv | 57 +++++
 rtl/video_timing_if.sv | 39 +++
 rtl/video_timing_ce_divider.sv | 64 ++++++
 rtl/video_timing.sv | 133 +++++++++++++
 tb/tb_video_timing.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_pkg
//  Description : Shared types and default raster constants for the video
//                timing generator. Defaults describe a 320x240 visible
//                raster inside a 400x262 total raster.
//  Contents    : counter/compare/frame types, flag bundle, default timing,
//                derived sync window edges, window-compare helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

    // Beam counters are 9 bits wide. All comparisons go through a 10-bit
    // intermediate so a 512-pixel or 512-line raster wraps without overflow.
    localparam int unsigned c_cnt_w   = 9;
    localparam int unsigned c_cmp_w   = 10;
    localparam int unsigned c_frame_w = 8;

    typedef logic [c_cnt_w-1:0]   cnt_t;
    typedef logic [c_cmp_w-1:0]   cmp_t;
    typedef logic [c_frame_w-1:0] frame_t;

    // Per-pixel raster flags, registered together with the beam counters.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblank;
        logic vblank;
        logic de;
    } flags_t;

    // Default timing
    localparam int unsigned c_ce_div   = 4;
    localparam int unsigned c_h_active = 320;
    localparam int unsigned c_h_fp     = 16;
    localparam int unsigned c_h_sync   = 32;
    localparam int unsigned c_h_bp     = 32;
    localparam int unsigned c_v_active = 240;
    localparam int unsigned c_v_fp     = 4;
    localparam int unsigned c_v_sync   = 3;
    localparam int unsigned c_v_bp     = 15;

    // Derived default geometry (sync windows are half-open: [start, end))
    localparam int unsigned c_h_total  = c_h_active + c_h_fp + c_h_sync + c_h_bp;
    localparam int unsigned c_v_total  = c_v_active + c_v_fp + c_v_sync + c_v_bp;
    localparam int unsigned c_hs_start = c_h_active + c_h_fp;
    localparam int unsigned c_hs_end   = c_hs_start + c_h_sync;
    localparam int unsigned c_vs_start = c_v_active + c_v_fp;
    localparam int unsigned c_vs_end   = c_vs_start + c_v_sync;

    // True when lo <= pos < hi.
    function automatic logic in_window(cmp_t pos, cmp_t lo, cmp_t hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_if.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_if
//  Description : Raster timing bundle passed from the timing generator to
//                the character-map renderer (and the CPU irq input).
//  Signals     : ce_pix     - one-clk pixel strobe
//                hcnt/vcnt  - beam position
//                hsync/vsync, hblank/vblank, de - raster flags
//                vblank_irq - one-clk strobe at vblank entry
//                frame_cnt  - completed frames, wrapping
//  Modports    : master (generator drives), slave (consumer reads)
//  Revision    : 1.0 - initial release
// ============================================================================
interface video_timing_if;
    import video_timing_pkg::*;

    logic   ce_pix;
    cnt_t   hcnt;
    cnt_t   vcnt;
    logic   hsync;
    logic   vsync;
    logic   hblank;
    logic   vblank;
    logic   de;
    logic   vblank_irq;
    frame_t frame_cnt;

    modport master (
        output ce_pix, hcnt, vcnt, hsync, vsync, hblank, vblank, de,
               vblank_irq, frame_cnt
    );

    modport slave (
        input  ce_pix, hcnt, vcnt, hsync, vsync, hblank, vblank, de,
               vblank_irq, frame_cnt
    );

endinterface
`default_nettype wire

// File: rtl/video_timing_ce_divider.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_ce_divider
//  Description : Pixel clock-enable divider. A counter runs 0..CE_DIV-1 and
//                ce_pix is registered high for exactly the clk in which the
//                counter holds CE_DIV-1. With CE_DIV=1 ce_pix is high on
//                every clk after the first edge out of reset.
//  Ports       : clk    - system clock
//                reset  - asynchronous active-low reset
//                ce_pix - registered one-clk pixel strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing_ce_divider #(
    parameter int unsigned CE_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic ce_pix
);

    logic r_ce;

    generate
        if (CE_DIV <= 1) begin : g_single
            // No counter needed: the strobe is simply held high.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_ce <= 1'b0;
                end else begin
                    r_ce <= 1'b1;
                end
            end
        end else begin : g_count
            localparam int unsigned          c_div_w    = $clog2(CE_DIV);
            localparam logic [c_div_w-1:0]   c_div_last = c_div_w'(CE_DIV - 1);

            logic [c_div_w-1:0] r_div;
            logic [c_div_w-1:0] w_div_next;

            always_comb begin
                w_div_next = r_div + 1'b1;
                if (r_div == c_div_last) begin
                    w_div_next = '0;
                end
            end

            // The strobe is registered from the next divider value so it is
            // high while r_div sits at its terminal count.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_div <= '0;
                    r_ce  <= 1'b0;
                end else begin
                    r_div <= w_div_next;
                    r_ce  <= (w_div_next == c_div_last);
                end
            end
        end
    endgenerate

    assign ce_pix = r_ce;

endmodule
`default_nettype wire

// File: rtl/video_timing.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing
//  Description : Raster timing generator feeding the character-map renderer.
//                Produces pixel strobe, 9-bit beam counters, sync/blank/de
//                flags, a one-clk vblank interrupt strobe and a frame count.
//                Every output is registered.
//  Ports       : clk   - system clock
//                reset - asynchronous active-low reset
//                vid   - video_timing_if master: ce_pix, hcnt, vcnt, hsync,
//                        vsync, hblank, vblank, de, vblank_irq, frame_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing
    import video_timing_pkg::*;
#(
    parameter int unsigned CE_DIV   = c_ce_div,
    parameter int unsigned H_ACTIVE = c_h_active,
    parameter int unsigned H_FP     = c_h_fp,
    parameter int unsigned H_SYNC   = c_h_sync,
    parameter int unsigned H_BP     = c_h_bp,
    parameter int unsigned V_ACTIVE = c_v_active,
    parameter int unsigned V_FP     = c_v_fp,
    parameter int unsigned V_SYNC   = c_v_sync,
    parameter int unsigned V_BP     = c_v_bp
) (
    input  logic           clk,
    input  logic           reset,
    video_timing_if.master vid
);

    // Geometry in compare width
    localparam cmp_t c_h_active_w = cmp_t'(H_ACTIVE);
    localparam cmp_t c_h_total_w  = cmp_t'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam cmp_t c_hs_start_w = cmp_t'(H_ACTIVE + H_FP);
    localparam cmp_t c_hs_end_w   = cmp_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cmp_t c_v_active_w = cmp_t'(V_ACTIVE);
    localparam cmp_t c_v_total_w  = cmp_t'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam cmp_t c_vs_start_w = cmp_t'(V_ACTIVE + V_FP);
    localparam cmp_t c_vs_end_w   = cmp_t'(V_ACTIVE + V_FP + V_SYNC);

    logic   w_ce;

    cnt_t   r_hcnt;
    cnt_t   r_vcnt;
    flags_t r_flags;
    logic   r_irq;
    frame_t r_frame_cnt;

    cmp_t   w_h_inc;
    cmp_t   w_h_next;
    logic   w_h_wrap;
    cmp_t   w_v_inc;
    cmp_t   w_v_next;
    logic   w_frame_wrap;
    flags_t w_flags_next;
    logic   w_irq_next;

    video_timing_ce_divider #(
        .CE_DIV (CE_DIV)
    ) u_ce_divider (
        .clk    (clk),
        .reset  (reset),
        .ce_pix (w_ce)
    );

    // Next beam position and the flags that belong to it. Flags are taken
    // from the next position so they always describe the counters they are
    // registered alongside.
    always_comb begin
        w_h_inc      = cmp_t'(r_hcnt) + cmp_t'(1);
        w_h_wrap     = (w_h_inc == c_h_total_w);
        w_h_next     = w_h_wrap ? '0 : w_h_inc;
        w_v_inc      = cmp_t'(r_vcnt) + cmp_t'(1);
        w_v_next     = cmp_t'(r_vcnt);
        w_frame_wrap = 1'b0;

        // Vertical state only moves on a line wrap, keeping vsync/vblank
        // line-aligned.
        if (w_h_wrap) begin
            if (w_v_inc == c_v_total_w) begin
                w_v_next     = '0;
                w_frame_wrap = 1'b1;
            end else begin
                w_v_next     = w_v_inc;
            end
        end

        w_flags_next.hblank = (w_h_next >= c_h_active_w);
        w_flags_next.vblank = (w_v_next >= c_v_active_w);
        w_flags_next.hsync  = in_window(w_h_next, c_hs_start_w, c_hs_end_w);
        w_flags_next.vsync  = in_window(w_v_next, c_vs_start_w, c_vs_end_w);
        w_flags_next.de     = ~w_flags_next.hblank & ~w_flags_next.vblank;

        // vblank entry happens only on the line wrap that lands on V_ACTIVE.
        w_irq_next = w_h_wrap && (w_v_next == c_v_active_w);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_flags     <= '0;
            r_irq       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            // The irq register is rewritten every clk so the strobe lasts
            // exactly one clk even when pixels span several clks.
            r_irq <= w_ce & w_irq_next;
            if (w_ce) begin
                r_hcnt  <= cnt_t'(w_h_next);
                r_vcnt  <= cnt_t'(w_v_next);
                r_flags <= w_flags_next;
                if (w_frame_wrap) begin
                    r_frame_cnt <= r_frame_cnt + frame_t'(1);
                end
            end
        end
    end

    assign vid.ce_pix     = w_ce;
    assign vid.hcnt       = r_hcnt;
    assign vid.vcnt       = r_vcnt;
    assign vid.hsync      = r_flags.hsync;
    assign vid.vsync      = r_flags.vsync;
    assign vid.hblank     = r_flags.hblank;
    assign vid.vblank     = r_flags.vblank;
    assign vid.de         = r_flags.de;
    assign vid.vblank_irq = r_irq;
    assign vid.frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_video_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_timing
//  Description : Self-checking bench for video_timing. Three instances:
//                A - default timing (CE_DIV=4, 400x262)
//                B - tiny raster (CE_DIV=2, 12x8) for long frame runs
//                C - CE_DIV=1 with a 512-pixel line
//                A scoreboard compares every clk against a closed-form model
//                indexed by clk count since reset release; directed checks
//                cover the hand-computed boundary points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing;
    import video_timing_pkg::*;

    typedef struct packed {
        logic       ce;
        logic [8:0] h;
        logic [8:0] v;
        logic       hs;
        logic       vs;
        logic       hb;
        logic       vb;
        logic       de;
        logic       irq;
        logic [7:0] fc;
    } obs_t;

    typedef struct {
        int ce; int ha; int hf; int hs; int hb; int va; int vf; int vs; int vb;
    } cfg_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    video_timing_if vid_a ();
    video_timing_if vid_b ();
    video_timing_if vid_c ();

    video_timing u_dut_a (
        .clk   (clk),
        .reset (reset),
        .vid   (vid_a)
    );

    video_timing #(
        .CE_DIV(2), .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(3),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .vid   (vid_b)
    );

    video_timing #(
        .CE_DIV(1), .H_ACTIVE(500), .H_FP(4), .H_SYNC(4), .H_BP(4),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_dut_c (
        .clk   (clk),
        .reset (reset),
        .vid   (vid_c)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_print  = 0;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic cfg_t cfg_of(int d);
        cfg_t c;
        case (d)
            0:       c = '{int'(c_ce_div), int'(c_h_active), int'(c_h_fp), int'(c_h_sync), int'(c_h_bp),
                           int'(c_v_active), int'(c_v_fp), int'(c_v_sync), int'(c_v_bp)};
            1:       c = '{2, 6, 1, 2, 3, 5, 1, 1, 1};
            default: c = '{1, 500, 4, 4, 4, 2, 1, 1, 1};
        endcase
        return c;
    endfunction

    // Expected outputs after the k-th clk edge since reset release (k=0:
    // in reset or before the first edge). The strobe is high after edges
    // k = CE-1, 2CE-1, ...; each strobe advances the beam on the following
    // edge, so n pixels have elapsed after edge k.
    function automatic obs_t model(int k, cfg_t c);
        obs_t e;
        int n, h, v, ht, vt;
        e = '0;
        if (k <= 0) return e;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        e.ce = ((k % c.ce) == (c.ce - 1));
        n = (c.ce == 1) ? k - 1 : k / c.ce;
        if (n > 0) begin
            h    = n % ht;
            v    = (n / ht) % vt;
            e.h  = 9'(h);
            e.v  = 9'(v);
            e.fc = 8'((n / (ht * vt)) % 256);
            e.hb = (h >= c.ha);
            e.vb = (v >= c.va);
            e.hs = (h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs);
            e.vs = (v >= c.va + c.vf) && (v < c.va + c.vf + c.vs);
            e.de = !e.hb && !e.vb;
            e.irq = ((k % c.ce) == 0) && ((n % (ht * vt)) == c.va * ht);
        end
        return e;
    endfunction

    function automatic obs_t sample(int d);
        obs_t o;
        case (d)
            0: o = {vid_a.ce_pix, vid_a.hcnt, vid_a.vcnt, vid_a.hsync, vid_a.vsync, vid_a.hblank,
                    vid_a.vblank, vid_a.de, vid_a.vblank_irq, vid_a.frame_cnt};
            1: o = {vid_b.ce_pix, vid_b.hcnt, vid_b.vcnt, vid_b.hsync, vid_b.vsync, vid_b.hblank,
                    vid_b.vblank, vid_b.de, vid_b.vblank_irq, vid_b.frame_cnt};
            default: o = {vid_c.ce_pix, vid_c.hcnt, vid_c.vcnt, vid_c.hsync, vid_c.vsync, vid_c.hblank,
                    vid_c.vblank, vid_c.de, vid_c.vblank_irq, vid_c.frame_cnt};
        endcase
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("ce=%0d h=%0d v=%0d hs=%0d vs=%0d hb=%0d vb=%0d de=%0d irq=%0d fc=%0d",
                         o.ce, o.h, o.v, o.hs, o.vs, o.hb, o.vb, o.de, o.irq, o.fc);
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard: the expectation producer pushes one entry per DUT after
    // each edge; the monitor pops and compares on the falling edge.
    // ------------------------------------------------------------------
    int   k = 0;
    obs_t q[3][$];

    always @(posedge clk) begin
        if (reset) k++;
        else       k = 0;
        #2;
        if (!reset) k = 0;
        for (int d = 0; d < 3; d++) q[d].push_back(model(k, cfg_of(d)));
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            obs_t e, a;
            n_checks++;
            if (q[d].size() == 0) begin
                n_fail++;
                $display("FAIL scb_dut%0d: got empty queue, expected an entry", d);
            end else begin
                e = q[d].pop_front();
                a = sample(d);
                if (a !== e) begin
                    n_fail++;
                    if (n_print < 20) begin
                        n_print++;
                        $display("FAIL scb_dut%0d k=%0d: got %s, expected %s", d, k, fmt(a), fmt(e));
                    end
                end
            end
        end
    end

    // Event tallies for the directed checks
    int irq_cnt_b = 0;
    bit saw_255_b = 0;
    bit saw_511_c = 0;
    always @(negedge clk) begin
        if (vid_b.vblank_irq)       irq_cnt_b++;
        if (vid_b.frame_cnt == 255) saw_255_b = 1'b1;
        if (vid_c.hcnt == 511)      saw_511_c = 1'b1;
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        int edges, hs_clks, de_bad, max_h, hb_rise;
        bit found, prev_hb;

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_a_hcnt", int'(vid_a.hcnt), 0);
        check("rst_a_de",   int'(vid_a.de), 0);
        check("rst_c_ce",   int'(vid_c.ce_pix), 0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;

        // First pixel strobe on A appears after the third edge
        edges = 0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); edges++;
            @(negedge clk);
            if (vid_a.ce_pix) found = 1'b1;
        end
        check("a_first_ce_edge", edges, 3);
        @(posedge clk); #1;
        check("a_hcnt_after_edge4", int'(vid_a.hcnt), 1);
        check("a_ce_after_edge4",   int'(vid_a.ce_pix), 0);
        check("c_hcnt_after_edge4", int'(vid_c.hcnt), 3);

        // One full line on A
        hs_clks = 0; de_bad = 0; max_h = 0; hb_rise = -1; found = 1'b0;
        prev_hb = vid_a.hblank;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (vid_a.vcnt == 9'd1) begin
                found = 1'b1;
            end else begin
                if (vid_a.hsync) hs_clks++;
                if (vid_a.de && vid_a.hblank) de_bad++;
                if (int'(vid_a.hcnt) > max_h) max_h = int'(vid_a.hcnt);
                if (vid_a.hblank && !prev_hb && hb_rise < 0) hb_rise = int'(vid_a.hcnt);
                prev_hb = vid_a.hblank;
            end
        end
        check("a_line_done",      int'(found), 1);
        check("a_hsync_clks",     hs_clks, 128);
        check("a_hcnt_max",       max_h, 399);
        check("a_hblank_rise_at", hb_rise, int'(c_h_active));
        check("a_de_in_hblank",   de_bad, 0);
        check("a_hcnt_at_wrap",   int'(vid_a.hcnt), 0);
        check("a_hblank_at_wrap", int'(vid_a.hblank), 0);

        // 256 frames of B (192 clks each)
        for (int i = 0; i < 60000 && k < 256 * 192; i++) @(negedge clk);
        @(posedge clk); #1;
        check("b_irq_per_256_frames", irq_cnt_b, 256);
        check("b_frame_wrapped",      int'(vid_b.frame_cnt), 0);
        check("b_saw_frame_255",      int'(saw_255_b), 1);
        check("c_saw_hcnt_511",       int'(saw_511_c), 1);

        // Reset asserted during B's irq clk
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk); #1;
            if (vid_b.vblank_irq) found = 1'b1;
        end
        check("b_irq_seen",  int'(found), 1);
        check("b_irq_vcnt",  int'(vid_b.vcnt), 5);
        check("b_irq_hcnt",  int'(vid_b.hcnt), 0);
        reset = 1'b0;
        #1;
        check("b_rst_irq",    int'(vid_b.vblank_irq), 0);
        check("b_rst_vblank", int'(vid_b.vblank), 0);
        check("b_rst_vcnt",   int'(vid_b.vcnt), 0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;

        // Next irq exactly one active field later: 5 lines * 12 px * 2 clks
        edges = 0; found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk); #1; edges++;
            if (vid_b.vblank_irq) found = 1'b1;
        end
        check("b_irq_after_restart", edges, 120);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
